// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debounce bank: event codes,
// the event record layout and the default timing constants for 50 MHz.
package debounce_pkg;

  // Event codes presented on evt_type.
  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_LONG    = 2'b11
  } evt_code_e;

  // Largest supported bank and the channel field that covers it.
  localparam int unsigned MAX_CH     = 16;
  localparam int unsigned CH_FIELD_W = 4;

  // One queued event: originating channel plus its code.
  typedef struct packed {
    logic [CH_FIELD_W-1:0] ch;
    evt_code_e             code;
  } evt_t;

  // 20 us debounce window and 1 s long-press threshold at 50 MHz.
  localparam int unsigned DEF_STABLE_CYCLES = 1000;
  localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-FF synchroniser, polarity normalisation,
// debounce counter, long-press hold counter and the three tick pulses.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned ACTIVE_LOW    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic pos_tick,
  output logic neg_tick,
  output logic long_tick
);

  localparam int unsigned CNT_W    = $clog2(STABLE_CYCLES);
  localparam int unsigned HOLD_THR = LONG_CYCLES - STABLE_CYCLES;
  localparam int unsigned HOLD_W   = (HOLD_THR > 0) ? $clog2(HOLD_THR + 1) : 1;

  localparam logic              IDLE_PIN  = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_THR);

  logic [1:0]        sync_q;
  logic              s;
  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_nxt;
  logic              flip;
  logic              hold_sat;

  // Synchroniser resets to the idle pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {2{IDLE_PIN}};
    end else begin
      sync_q <= {sync_q[0], sw};
    end
  end

  assign s        = (ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];
  assign flip     = (s != db_level) && (cnt == CNT_LAST);
  assign hold_sat = (hold == HOLD_LAST);
  assign hold_nxt = hold + 1'b1;

  // Debounce: count consecutive disagreeing samples, flip the level on the last one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      db_level <= 1'b0;
      pos_tick <= 1'b0;
      neg_tick <= 1'b0;
    end else begin
      pos_tick <= flip & s;
      neg_tick <= flip & ~s;
      if ((s == db_level) || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (flip) begin
        db_level <= s;
      end
    end
  end

  // Hold counter restarts with each press and saturates so only one long tick fires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold      <= '0;
      long_tick <= 1'b0;
    end else begin
      long_tick <= 1'b0;
      if (flip && s) begin
        hold      <= '0;
        long_tick <= (HOLD_THR == 0);
      end else if (db_level && !hold_sat) begin
        hold      <= hold_nxt;
        long_tick <= (hold_nxt == HOLD_LAST);
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// N-channel debounce bank: per-channel debouncers plus a pending-event
// store that serialises press/long/release events onto one ready/valid port.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH          = 5,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned ACTIVE_LOW    = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [N_CH-1:0]                         sw,
  input  logic                                    clr_ovf,
  output logic [N_CH-1:0]                         db_level,
  output logic [N_CH-1:0]                         pos_tick,
  output logic [N_CH-1:0]                         neg_tick,
  output logic [N_CH-1:0]                         long_tick,
  output logic                                    evt_valid,
  input  logic                                    evt_ready,
  output logic [$clog2(N_CH > 1 ? N_CH : 2)-1:0]  evt_ch,
  output logic [1:0]                              evt_type,
  output logic                                    evt_overflow
);

  localparam int unsigned CH_W = $clog2(N_CH > 1 ? N_CH : 2);

  logic [N_CH-1:0] pend_press, pend_long, pend_rel;
  logic [N_CH-1:0] take_press, take_long, take_rel;
  logic [N_CH-1:0] clr_press, clr_long, clr_rel;
  logic [N_CH-1:0] nxt_press, nxt_long, nxt_rel;
  logic [N_CH-1:0] ovf_vec;
  logic            load;
  logic            found;
  logic            ovf_hit;
  logic [CH_W-1:0] sel_ch;
  evt_code_e       sel_code;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .sw       (sw[g]),
      .db_level (db_level[g]),
      .pos_tick (pos_tick[g]),
      .neg_tick (neg_tick[g]),
      .long_tick(long_tick[g])
    );
  end

  assign load = !evt_valid || evt_ready;

  // Priority pick over pending bits and this cycle's ticks, so a fresh tick
  // reaches evt_valid one cycle later: lowest channel, then press > long > release.
  always_comb begin
    found      = 1'b0;
    sel_ch     = '0;
    sel_code   = EVT_NONE;
    take_press = '0;
    take_long  = '0;
    take_rel   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!found) begin
        if (pend_press[i] || pos_tick[i]) begin
          found         = 1'b1;
          sel_ch        = CH_W'(i);
          sel_code      = EVT_PRESS;
          take_press[i] = 1'b1;
        end else if (pend_long[i] || long_tick[i]) begin
          found        = 1'b1;
          sel_ch       = CH_W'(i);
          sel_code     = EVT_LONG;
          take_long[i] = 1'b1;
        end else if (pend_rel[i] || neg_tick[i]) begin
          found       = 1'b1;
          sel_ch      = CH_W'(i);
          sel_code    = EVT_RELEASE;
          take_rel[i] = 1'b1;
        end
      end
    end
  end

  assign clr_press = take_press & {N_CH{load}};
  assign clr_long  = take_long  & {N_CH{load}};
  assign clr_rel   = take_rel   & {N_CH{load}};

  // A loaded bit that was already pending lets a same-cycle tick re-set it;
  // a loaded bit fed only by the tick consumes that tick directly.
  assign nxt_press = (pend_press & ~clr_press) | (pos_tick  & ~(clr_press & ~pend_press));
  assign nxt_long  = (pend_long  & ~clr_long)  | (long_tick & ~(clr_long  & ~pend_long));
  assign nxt_rel   = (pend_rel   & ~clr_rel)   | (neg_tick  & ~(clr_rel   & ~pend_rel));

  assign ovf_vec = (pos_tick  & pend_press & ~clr_press)
                 | (long_tick & pend_long  & ~clr_long)
                 | (neg_tick  & pend_rel   & ~clr_rel);
  assign ovf_hit = |ovf_vec;

  // Pending event bits per channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_press <= '0;
      pend_long  <= '0;
      pend_rel   <= '0;
    end else begin
      pend_press <= nxt_press;
      pend_long  <= nxt_long;
      pend_rel   <= nxt_rel;
    end
  end

  // Output register: reloads whenever empty or accepted, holds under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_type  <= EVT_NONE;
    end else if (load) begin
      evt_valid <= found;
      if (found) begin
        evt_ch   <= sel_ch;
        evt_type <= sel_code;
      end
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_overflow <= 1'b0;
    end else if (ovf_hit) begin
      evt_overflow <= 1'b1;
    end else if (clr_ovf) begin
      evt_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with a window-based behavioural model
// checked every cycle plus hand-computed latency and event-order expectations.
module tb_debounce_bank;

  localparam int N   = 5;
  localparam int S   = 16;
  localparam int L   = 64;
  localparam int THR = L - S;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] sw = '1;
  logic         clr_ovf = 1'b0;
  logic         evt_ready = 1'b0;
  logic [N-1:0] db_level, pos_tick, neg_tick, long_tick;
  logic         evt_valid;
  logic [2:0]   evt_ch;
  logic [1:0]   evt_type;
  logic         evt_overflow;

  debounce_bank #(
    .N_CH(N), .STABLE_CYCLES(S), .LONG_CYCLES(L), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .clr_ovf(clr_ovf),
    .db_level(db_level), .pos_tick(pos_tick), .neg_tick(neg_tick),
    .long_tick(long_tick), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .evt_type(evt_type), .evt_overflow(evt_overflow)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // Level flips once the last S synchronised samples since the previous
  // flip all disagree with it; long fires THR edges after the rising edge.
  // Pending events are a list of keys ch*3+prio (press 0, long 1, release 2).
  logic [N-1:0] m_s1, m_s2, m_db, m_pos, m_neg, m_long;
  logic [S-1:0] hist [N];
  int           fill [N];
  int           m_rise [N];
  int           m_pend [$];
  int           m_tk [$];
  bit           m_valid;
  int           m_key;
  bit           m_ovf;
  int           m_t;
  int           mb_best;
  bit           mb_hit;
  bit           mb_done;
  logic [N-1:0] mb_pos, mb_neg, mb_long;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_pos = '0; m_neg = '0; m_long = '0;
      for (int c = 0; c < N; c++) begin
        hist[c] = '0; fill[c] = 0; m_rise[c] = -100000;
      end
      m_pend.delete(); m_valid = 0; m_key = 0; m_ovf = 0; m_t = 0;
    end else begin
      m_t++;
      m_tk.delete();
      for (int c = 0; c < N; c++) begin
        if (m_pos[c])  m_tk.push_back(c * 3);
        if (m_long[c]) m_tk.push_back(c * 3 + 1);
        if (m_neg[c])  m_tk.push_back(c * 3 + 2);
      end
      mb_hit = 0;
      if (!m_valid || evt_ready) begin
        mb_best = -1;
        foreach (m_pend[i]) if (mb_best < 0 || m_pend[i] < mb_best) mb_best = m_pend[i];
        foreach (m_tk[i])   if (mb_best < 0 || m_tk[i] < mb_best)   mb_best = m_tk[i];
        m_valid = (mb_best >= 0);
        if (mb_best >= 0) begin
          m_key = mb_best;
          mb_done = 0;
          for (int j = 0; j < m_pend.size(); j++)
            if (!mb_done && m_pend[j] == mb_best) begin m_pend.delete(j); mb_done = 1; end
          for (int j = 0; j < m_tk.size(); j++)
            if (!mb_done && m_tk[j] == mb_best) begin m_tk.delete(j); mb_done = 1; end
        end
      end
      foreach (m_tk[i]) begin
        mb_done = 0;
        foreach (m_pend[j]) if (m_pend[j] == m_tk[i]) mb_done = 1;
        if (mb_done) mb_hit = 1;
        else m_pend.push_back(m_tk[i]);
      end
      if (mb_hit) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;

      mb_pos = '0; mb_neg = '0; mb_long = '0;
      for (int c = 0; c < N; c++) begin
        hist[c] = {hist[c][S-2:0], m_s2[c]};
        if (fill[c] < S) fill[c]++;
        if (m_db[c] && (m_t - m_rise[c] == THR)) mb_long[c] = 1'b1;
        if (fill[c] == S && hist[c] == {S{~m_db[c]}}) begin
          m_db[c] = m_s2[c];
          fill[c] = 0;
          if (m_s2[c]) begin mb_pos[c] = 1'b1; m_rise[c] = m_t; end
          else mb_neg[c] = 1'b1;
        end
      end
      m_pos = mb_pos; m_neg = mb_neg; m_long = mb_long;
      m_s2 = m_s1;
      m_s1 = ~sw;
    end
  end

  // ---------------- compare + monitor ----------------
  int log_q [$];
  int log_cyc [$];
  int last_pos [N], last_neg [N], last_long [N];
  int pos_cnt [N], neg_cnt [N], long_cnt [N];

  always @(negedge clk) begin
    check("db_level",  int'(db_level),  int'(m_db));
    check("pos_tick",  int'(pos_tick),  int'(m_pos));
    check("neg_tick",  int'(neg_tick),  int'(m_neg));
    check("long_tick", int'(long_tick), int'(m_long));
    check("evt_valid", int'(evt_valid), int'(m_valid));
    check("evt_overflow", int'(evt_overflow), int'(m_ovf));
    if (m_valid && evt_valid) begin
      check("evt_ch", int'(evt_ch), m_key / 3);
      check("evt_type", int'(evt_type), (m_key % 3 == 0) ? 1 : (m_key % 3 == 1) ? 3 : 2);
    end
    if (evt_valid && evt_ready) begin
      log_q.push_back(int'(evt_ch) * 4 + int'(evt_type));
      log_cyc.push_back(cyc);
    end
    for (int c = 0; c < N; c++) begin
      if (pos_tick[c])  begin last_pos[c]  = cyc; pos_cnt[c]++;  end
      if (neg_tick[c])  begin last_neg[c]  = cyc; neg_cnt[c]++;  end
      if (long_tick[c]) begin last_long[c] = cyc; long_cnt[c]++; end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #5; end
  endtask

  task automatic clear_mon();
    log_q.delete(); log_cyc.delete();
    for (int c = 0; c < N; c++) begin pos_cnt[c] = 0; neg_cnt[c] = 0; long_cnt[c] = 0; end
  endtask

  task automatic check_log(input string name, input int idx, input int exp);
    check(name, (idx < log_q.size()) ? log_q[idx] : -1, exp);
  endtask

  int c0, c1;

  initial begin
    step(3);
    check("reset_outputs", int'({db_level, pos_tick, neg_tick, long_tick,
                                 evt_valid, evt_ch, evt_type, evt_overflow}), 0);
    reset = 1'b1;
    step(2);

    // Clean press on ch0.
    clear_mon();
    evt_ready = 1'b1;
    sw[0] = 1'b0; c0 = cyc;
    step(40);
    sw[0] = 1'b1; c1 = cyc;
    step(40);
    check("clean_pos_lat", last_pos[0] - c0, 18);
    check("clean_neg_lat", last_neg[0] - c1, 18);
    check("clean_log_len", log_q.size(), 2);
    check_log("clean_evt0", 0, 0 * 4 + 1);
    check_log("clean_evt1", 1, 0 * 4 + 2);

    // Glitchy press on ch1.
    clear_mon();
    for (int k = 0; k < 4; k++) begin
      sw[1] = ~sw[1];
      step(5);
    end
    check("glitch_no_tick", pos_cnt[1] + neg_cnt[1], 0);
    sw[1] = 1'b0; c0 = cyc;
    step(40);
    check("glitch_pos_cnt", pos_cnt[1], 1);
    check("glitch_pos_lat", last_pos[1] - c0, 18);
    sw[1] = 1'b1;
    step(40);

    // Long press on ch2.
    clear_mon();
    sw[2] = 1'b0; c0 = cyc;
    step(100);
    sw[2] = 1'b1;
    step(40);
    check("long_lat", last_long[2] - c0, 66);
    check("long_cnt", long_cnt[2], 1);
    check("long_log_len", log_q.size(), 3);
    check_log("long_evt0", 0, 2 * 4 + 1);
    check_log("long_evt1", 1, 2 * 4 + 3);
    check_log("long_evt2", 2, 2 * 4 + 2);

    // Simultaneous press/release on all channels.
    clear_mon();
    sw = '0;
    step(40);
    sw = '1;
    step(40);
    check("simul_log_len", log_q.size(), 10);
    for (int c = 0; c < N; c++) begin
      check_log("simul_press", c, c * 4 + 1);
      check_log("simul_release", N + c, c * 4 + 2);
    end
    check("simul_back_to_back", (log_cyc.size() >= N) ? log_cyc[N-1] - log_cyc[0] : -1, N - 1);

    // Backpressure and overflow on ch3.
    clear_mon();
    evt_ready = 1'b0;
    sw[3] = 1'b0; step(30);
    check("bp_valid_a", int'(evt_valid), 1);
    check("bp_evt_a", int'(evt_ch) * 4 + int'(evt_type), 3 * 4 + 1);
    sw[3] = 1'b1; step(30);
    sw[3] = 1'b0; step(30);
    sw[3] = 1'b1; step(30);
    check("bp_overflow", int'(evt_overflow), 1);
    check("bp_valid_b", int'(evt_valid), 1);
    check("bp_evt_b", int'(evt_ch) * 4 + int'(evt_type), 3 * 4 + 1);
    clr_ovf = 1'b1; step(1); clr_ovf = 1'b0;
    check("bp_ovf_cleared", int'(evt_overflow), 0);
    evt_ready = 1'b1;
    step(6);
    check("bp_log_len", log_q.size(), 3);
    check_log("bp_evt0", 0, 3 * 4 + 1);
    check_log("bp_evt1", 1, 3 * 4 + 1);
    check_log("bp_evt2", 2, 3 * 4 + 2);

    // Reset in the middle of a debounce count on ch0, with ch4 held pressed.
    sw[4] = 1'b0; step(30);
    check("rst_pre_level", int'(db_level[4]), 1);
    sw[0] = 1'b0; step(12);
    reset = 1'b0;
    sw = '1;
    #1;
    check("rst_outputs", int'({db_level, pos_tick, neg_tick, long_tick,
                               evt_valid, evt_ch, evt_type, evt_overflow}), 0);
    step(2);
    reset = 1'b1;
    clear_mon();
    step(40);
    check("rst_no_ticks", pos_cnt[0] + neg_cnt[0] + pos_cnt[4] + neg_cnt[4], 0);
    check("rst_no_events", log_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
